// File: rtl/vend_session_driver.sv
// Vending-machine session driver: card insert, two-digit key entry, price
// authorisation against the card balance, vend/door handshake and status report.
module vend_session_driver #(
    parameter int KEY_GAP      = 1,
    parameter int DOOR_CYCLES  = 3,
    parameter int RESP_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [3:0] SEL_TENS,
    input  logic [3:0] SEL_ONES,
    input  logic [7:0] BALANCE_IN,
    input  logic       VEND,
    input  logic       INVALID_SEL,
    input  logic [2:0] COST,
    input  logic       FAILED_TRAN,
    output logic       CARD_IN,
    output logic [3:0] ITEM_CODE,
    output logic       KEY_PRESS,
    output logic       VALID_TRAN,
    output logic       DOOR_OPEN,
    output logic       BUSY,
    output logic       DONE,
    output logic [2:0] STATUS,
    output logic [2:0] CHARGED,
    output logic [7:0] BALANCE_OUT
);
    localparam logic [3:0] S_IDLE = 4'd0, S_INSERT = 4'd1, S_KEY1 = 4'd2, S_GAP = 4'd3,
                           S_KEY2 = 4'd4, S_WAIT_COST = 4'd5, S_AUTH = 4'd6,
                           S_WAIT_VEND = 4'd7, S_DOOR = 4'd8, S_CLOSE = 4'd9,
                           S_WAIT_FAIL = 4'd10, S_FIN = 4'd11;

    localparam logic [2:0] ST_OK = 3'd1, ST_INVALID = 3'd2, ST_DECLINED = 3'd3,
                           ST_FAILED = 3'd4, ST_TIMEOUT = 3'd5;

    logic [3:0] state, nxt;
    logic [3:0] tens, ones;
    logic [7:0] bal;
    logic [2:0] cost_q, charged, status;
    logic [4:0] tmo;
    logic [3:0] cnt;
    logic       st_set;
    logic [2:0] st_val;
    logic       tmo_hit, approve, counting;

    assign tmo_hit  = tmo >= 5'(RESP_TIMEOUT);
    assign approve  = {5'b0, cost_q} <= bal;
    assign counting = (state == S_WAIT_COST) || (state == S_WAIT_VEND) ||
                      (state == S_CLOSE) || (state == S_WAIT_FAIL);

    always_comb begin
        nxt    = state;
        st_set = 1'b0;
        st_val = 3'd0;
        case (state)
            S_IDLE:      if (START) nxt = S_INSERT;
            S_INSERT:    nxt = S_KEY1;
            S_KEY1:      nxt = S_GAP;
            S_GAP:       if (cnt == 4'(KEY_GAP - 1)) nxt = S_KEY2;
            S_KEY2:      nxt = S_WAIT_COST;
            S_WAIT_COST: begin
                if (INVALID_SEL) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_INVALID;
                end else if (COST != 3'd0) begin
                    nxt = S_AUTH;
                end else if (tmo_hit) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_TIMEOUT;
                end
            end
            S_AUTH:      nxt = approve ? S_WAIT_VEND : S_WAIT_FAIL;
            S_WAIT_VEND: begin
                // VEND outranks a same-cycle FAILED_TRAN
                if (VEND) begin
                    nxt = S_DOOR;
                end else if (FAILED_TRAN) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_FAILED;
                end else if (tmo_hit) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_TIMEOUT;
                end
            end
            S_DOOR:      if (cnt == 4'(DOOR_CYCLES - 1)) nxt = S_CLOSE;
            S_CLOSE: begin
                if (!VEND) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_OK;
                end else if (tmo_hit) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_TIMEOUT;
                end
            end
            S_WAIT_FAIL: begin
                if (FAILED_TRAN) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_DECLINED;
                end else if (tmo_hit) begin
                    nxt = S_FIN; st_set = 1'b1; st_val = ST_TIMEOUT;
                end
            end
            S_FIN:       nxt = S_IDLE;
            default:     nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= S_IDLE;
            tens    <= '0;
            ones    <= '0;
            bal     <= '0;
            cost_q  <= '0;
            charged <= '0;
            status  <= '0;
            tmo     <= '0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            // Both counters restart on every state change; cnt paces GAP and DOOR.
            if (nxt != state) begin
                tmo <= '0;
                cnt <= '0;
            end else begin
                if (counting && tmo != 5'h1f) tmo <= tmo + 5'd1;
                if (state == S_GAP || state == S_DOOR) cnt <= cnt + 4'd1;
            end
            if (st_set) status <= st_val;
            if (state == S_IDLE && START) begin
                tens    <= SEL_TENS;
                ones    <= SEL_ONES;
                bal     <= BALANCE_IN;
                charged <= '0;
                cost_q  <= '0;
                status  <= '0;
            end
            if (state == S_WAIT_COST && !INVALID_SEL && COST != 3'd0) cost_q <= COST;
            if (state == S_WAIT_VEND && VEND) begin
                bal     <= bal - {5'b0, cost_q};
                charged <= cost_q;
            end
        end
    end

    assign CARD_IN     = state == S_INSERT;
    assign KEY_PRESS   = (state == S_KEY1) || (state == S_KEY2);
    assign ITEM_CODE   = (state == S_KEY1 || state == S_GAP) ? tens :
                         (state == S_KEY2) ? ones : 4'd0;
    assign VALID_TRAN  = (state == S_AUTH) && approve;
    assign DOOR_OPEN   = state == S_DOOR;
    assign BUSY        = state != S_IDLE;
    assign DONE        = state == S_FIN;
    assign STATUS      = status;
    assign CHARGED     = charged;
    assign BALANCE_OUT = bal;
endmodule
